// File: rtl/dckt_operand_loader.sv
// Byte-serial to parallel operand loader for the dckt datapath, with result capture and
// inter-byte timeout. Define DCKT_LOADER_FRAME_CNT_EN to add the frame_count output.
module dckt_operand_loader #(
  parameter int unsigned WIDTH          = 8,
  parameter int unsigned TIMEOUT_CYCLES = 255
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [WIDTH-1:0] in_data,
  input  logic             in_valid,
  output logic             in_ready,
  output logic [WIDTH-1:0] a,
  output logic [WIDTH-1:0] b,
  output logic [WIDTH-1:0] c,
  output logic [WIDTH-1:0] d,
  output logic [WIDTH-1:0] e,
  output logic [WIDTH-1:0] f,
  output logic [WIDTH-1:0] g,
  output logic             frame_valid,
  input  logic             frame_ready,
  input  logic [WIDTH-1:0] y_in,
  output logic [WIDTH-1:0] result,
  output logic             result_valid,
  output logic             abort_pulse
`ifdef DCKT_LOADER_FRAME_CNT_EN
  ,
  output logic [15:0]      frame_count
`endif
);

  typedef enum logic {
    COLLECT = 1'b0,
    FULL    = 1'b1
  } state_t;

  localparam logic [2:0]  LAST_IDX = 3'd6;
  // The counter never holds TIMEOUT_CYCLES itself: the idle edge that would reach it aborts instead.
  localparam logic [15:0] TO_LAST  = 16'(TIMEOUT_CYCLES - 1);

  state_t           state_q;
  logic [2:0]       idx_q;
  logic [15:0]      to_cnt_q;
  logic [WIDTH-1:0] ops_q [7];
  logic [WIDTH-1:0] result_q;
  logic             in_ready_q;
  logic             frame_valid_q;
  logic             result_valid_q;
  logic             abort_pulse_q;
`ifdef DCKT_LOADER_FRAME_CNT_EN
  logic [15:0]      frame_count_q;
`endif

  logic accept;
  assign accept = in_valid && in_ready_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q        <= COLLECT;
      idx_q          <= '0;
      to_cnt_q       <= '0;
      in_ready_q     <= 1'b0;
      frame_valid_q  <= 1'b0;
      result_valid_q <= 1'b0;
      abort_pulse_q  <= 1'b0;
      result_q       <= '0;
      // NOTE: the operand bank is only seven registers and dckt must see defined zeros
      // after reset, so it is reset like ordinary state rather than left as an unreset RAM.
      for (int i = 0; i < 7; i++) ops_q[i] <= '0;
`ifdef DCKT_LOADER_FRAME_CNT_EN
      frame_count_q  <= '0;
`endif
    end else begin
      // NOTE: every register here uses <= so all updates see the pre-edge values,
      // independent of statement order.
      result_valid_q <= 1'b0;
      abort_pulse_q  <= 1'b0;
      case (state_q)
        COLLECT: begin
          in_ready_q <= 1'b1;
          if (accept) begin
            ops_q[idx_q] <= in_data;
            to_cnt_q     <= '0;
            if (idx_q == LAST_IDX) begin
              idx_q         <= '0;
              state_q       <= FULL;
              in_ready_q    <= 1'b0;
              frame_valid_q <= 1'b1;
            end else begin
              idx_q <= idx_q + 3'd1;
            end
          end else if (idx_q != 3'd0) begin
            if (to_cnt_q == TO_LAST) begin
              idx_q         <= '0;
              to_cnt_q      <= '0;
              abort_pulse_q <= 1'b1;
            end else begin
              to_cnt_q <= to_cnt_q + 16'd1;
            end
          end
        end
        FULL: begin
          if (frame_ready) begin
            result_q       <= y_in;
            result_valid_q <= 1'b1;
            frame_valid_q  <= 1'b0;
            in_ready_q     <= 1'b1;
            state_q        <= COLLECT;
`ifdef DCKT_LOADER_FRAME_CNT_EN
            frame_count_q  <= frame_count_q + 16'd1;
`endif
          end
        end
        default: state_q <= COLLECT;
      endcase
    end
  end

  assign in_ready     = in_ready_q;
  assign frame_valid  = frame_valid_q;
  assign result       = result_q;
  assign result_valid = result_valid_q;
  assign abort_pulse  = abort_pulse_q;
  assign a = ops_q[0];
  assign b = ops_q[1];
  assign c = ops_q[2];
  assign d = ops_q[3];
  assign e = ops_q[4];
  assign f = ops_q[5];
  assign g = ops_q[6];
`ifdef DCKT_LOADER_FRAME_CNT_EN
  assign frame_count  = frame_count_q;
`endif

endmodule

// File: tb/tb_dckt_operand_loader.sv
// Directed self-checking bench for dckt_operand_loader (TIMEOUT_CYCLES = 4).
`timescale 1ns/1ps
module tb_dckt_operand_loader;

  localparam int W  = 8;
  localparam int TO = 4;

  logic         clk = 1'b0;
  logic         rst_n = 1'b0;
  logic [W-1:0] in_data = '0;
  logic         in_valid = 1'b0;
  logic         in_ready;
  logic [W-1:0] a, b, c, d, e, f, g;
  logic         frame_valid;
  logic         frame_ready = 1'b0;
  logic [W-1:0] y_in = '0;
  logic [W-1:0] result;
  logic         result_valid;
  logic         abort_pulse;
`ifdef DCKT_LOADER_FRAME_CNT_EN
  logic [15:0]  frame_count;
`endif

  int checks = 0;
  int errors = 0;
  int excl_viol = 0;
  int fc_exp = 0;

  dckt_operand_loader #(.WIDTH(W), .TIMEOUT_CYCLES(TO)) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .in_data      (in_data),
    .in_valid     (in_valid),
    .in_ready     (in_ready),
    .a            (a),
    .b            (b),
    .c            (c),
    .d            (d),
    .e            (e),
    .f            (f),
    .g            (g),
    .frame_valid  (frame_valid),
    .frame_ready  (frame_ready),
    .y_in         (y_in),
    .result       (result),
    .result_valid (result_valid),
    .abort_pulse  (abort_pulse)
`ifdef DCKT_LOADER_FRAME_CNT_EN
    ,
    .frame_count  (frame_count)
`endif
  );

  always #5 clk = ~clk;

  always @(negedge clk) if (rst_n && in_ready && frame_valid) excl_viol++;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic logic [63:0] ops();
    return {8'h00, a, b, c, d, e, f, g};
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic send_byte(input logic [7:0] v);
    int n = 0;
    in_data  = v;
    in_valid = 1'b1;
    while (!in_ready && n < 40) begin
      tick();
      n++;
    end
    check("send_wait", 64'(in_ready), 64'h1);
    tick();
    in_valid = 1'b0;
  endtask

  task automatic send_frame(input logic [55:0] fr);
    for (int i = 0; i < 7; i++) send_byte(fr[55-8*i -: 8]);
  endtask

  task automatic check_count();
`ifdef DCKT_LOADER_FRAME_CNT_EN
    check("frame_count", 64'(frame_count), 64'(fc_exp));
`endif
  endtask

  task automatic handshake(input logic [7:0] y, input string tag);
    int n = 0;
    while (!frame_valid && n < 40) begin
      tick();
      n++;
    end
    check({tag, "_fv_before"}, 64'(frame_valid), 64'h1);
    y_in        = y;
    frame_ready = 1'b1;
    tick();
    frame_ready = 1'b0;
    fc_exp++;
    check({tag, "_result"}, 64'(result), 64'(y));
    check({tag, "_rv"}, {62'h0, result_valid, frame_valid}, 64'h2);
    check({tag, "_in_ready"}, 64'(in_ready), 64'h1);
    check_count();
    tick();
    check({tag, "_rv_once"}, 64'(result_valid), 64'h0);
  endtask

  localparam logic [55:0] BASIC = 56'h5269BCD1FF9F2D;
  logic [55:0] stall_frm [3] = '{56'h0123456789ABCD, 56'hFEDCBA98765432, 56'h00FF00FF00FF00};
  logic [7:0]  stall_res [3] = '{8'h11, 8'hEE, 8'h7E};
  int          stall_gap [3][7] = '{'{0, 1, 3, 2, 0, 3, 1}, '{2, 0, 0, 3, 1, 1, 0}, '{3, 3, 0, 1, 2, 0, 3}};
  int          stall_dly [3] = '{0, 5, 2};

  initial begin
    // Reset values
    #12;
    check("rst_ops", ops(), 64'h0);
    check("rst_flags", {59'h0, in_ready, frame_valid, result_valid, abort_pulse, 1'b0}, 64'h0);
    check("rst_result", 64'(result), 64'h0);
    @(negedge clk);
    rst_n = 1'b1;
    #1;
    check("rdy_before_edge", 64'(in_ready), 64'h0);
    tick();
    check("rdy_after_edge", 64'(in_ready), 64'h1);

    // Basic frame, held in FULL while y_in moves
    send_frame(BASIC);
    check("basic_ops", ops(), {8'h00, BASIC});
    check("basic_fv", {62'h0, frame_valid, in_ready}, 64'h2);
    for (int i = 0; i < 10; i++) begin
      y_in = 8'(i * 37 + 3);
      tick();
      check("basic_hold", {6'h0, in_ready, frame_valid, ops()[55:0]}, {6'h0, 1'b0, 1'b1, BASIC});
    end

    // Capture
    handshake(8'hA5, "capture");

    // Timeout: abort exactly 4 cycles after the last accept
    send_byte(8'h11);
    send_byte(8'h22);
    for (int k = 1; k <= 6; k++) begin
      tick();
      check("to_abort", 64'(abort_pulse), 64'(k == 4));
    end
    send_byte(8'h33);
    check("to_reload", {48'h0, a, b}, 64'h3322);

    // Timeout race: byte on the 4th idle edge wins
    for (int k = 1; k <= 3; k++) begin
      tick();
      check("race_idle", 64'(abort_pulse), 64'h0);
    end
    send_byte(8'h44);
    check("race_no_abort", 64'(abort_pulse), 64'h0);
    check("race_slot", {48'h0, a, b}, 64'h3344);
    for (int k = 1; k <= 3; k++) begin
      tick();
      check("race_cleared", 64'(abort_pulse), 64'h0);
    end
    send_byte(8'h55);
    send_byte(8'h66);
    send_byte(8'h77);
    send_byte(8'h88);
    send_byte(8'h99);
    check("race_ops", ops(), 64'h00334455667788_99);
    handshake(8'h5A, "race");

    // Stall / backpressure
    for (int fi = 0; fi < 3; fi++) begin
      for (int i = 0; i < 7; i++) begin
        for (int s = 0; s < stall_gap[fi][i]; s++) tick();
        send_byte(stall_frm[fi][55-8*i -: 8]);
      end
      for (int s = 0; s < stall_dly[fi]; s++) tick();
      check("stall_ops", ops(), {8'h00, stall_frm[fi]});
      handshake(stall_res[fi], "stall");
    end

    // Asynchronous reset mid-frame, then a frame with frame_ready held high throughout
    send_frame_partial();
    #3;
    rst_n = 1'b0;
    #1;
    fc_exp = 0;
    check("mid_rst_ops", ops(), 64'h0);
    check("mid_rst_flags", {59'h0, in_ready, frame_valid, result_valid, abort_pulse, 1'b0}, 64'h0);
    check("mid_rst_result", 64'(result), 64'h0);
    check_count();
    @(negedge clk);
    rst_n = 1'b1;
    frame_ready = 1'b1;
    y_in = 8'h3C;
    send_frame(56'hC0C1C2C3C4C5C6);
    check("post_ops", ops(), 64'h00C0C1C2C3C4C5C6);
    check("post_ignored", {55'h0, result, frame_valid}, {55'h0, 8'h00, 1'b1});
    tick();
    frame_ready = 1'b0;
    fc_exp++;
    check("post_capture", {54'h0, result, result_valid, frame_valid}, {54'h0, 8'h3C, 1'b1, 1'b0});
    check_count();

    check("ready_vs_valid", 64'(excl_viol), 64'h0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  task automatic send_frame_partial();
    send_byte(8'hA1);
    send_byte(8'hA2);
    send_byte(8'hA3);
    send_byte(8'hA4);
    check("partial_ops", {32'h0, a, b, c, d}, 64'hA1A2A3A4);
  endtask

endmodule
